// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: load-type codes, FSM
// encoding and the load-result extension helper.
package dmem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmemState_t;

  // Select the addressed lane(s) of a memory word and sign/zero-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  loadInst);
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    byteSel = word[{offset, 3'b000} +: 8];
    halfSel = offset[1] ? word[31:16] : word[15:0];
    case (loadInst)
      LB:      load_extend = {{24{byteSel[7]}}, byteSel};
      LH:      load_extend = {{16{halfSel[15]}}, halfSel};
      LW:      load_extend = word;
      LBU:     load_extend = {24'h00_0000, byteSel};
      LHU:     load_extend = {16'h0000, halfSel};
      default: load_extend = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised SRAM model: one registered read port and one byte-masked
// write port on the same clock. Contents are never reset.
module dmem_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rdEn,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [31:0]      rdData,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [3:0]       wrMask,
  input  logic [31:0]      wrData
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Registered read; holds the last read word while rdEn is low.
  always_ff @(posedge clk) begin
    if (rdEn) begin
      rdData <= mem_r[rdIdx];
    end
  end

  // Byte-lane masked write.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (wrMask[lane]) begin
          mem_r[wrIdx][lane*8 +: 8] <= wrData[lane*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time over valid/ready, SRAM access
// after a programmable latency, registered response held until accepted.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_wen,
  input  logic [2:0]            req_load_inst,
  input  logic [3:0]            req_store_mask,
  input  logic [DATA_WIDTH-1:0] req_store_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH_WORDS);

  dmemState_t            state_r, nextState_s;
  logic [CNT_W-1:0]      cnt_r, nextCnt_s;
  logic                  accept_s, enterResp_s;
  logic                  reqReady_r, respValid_r, respErr_r, loadOk_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  wen_r;
  logic [2:0]            inst_r;
  logic [3:0]            mask_r;
  logic [DATA_WIDTH-1:0] data_r;

  logic [ADDR_WIDTH-1:0] curAddr_s, offset_s;
  logic                  curWen_s;
  logic [2:0]            curInst_s;
  logic [3:0]            curMask_s;
  logic [DATA_WIDTH-1:0] curData_s;
  logic                  inRange_s, misaligned_s, illegal_s, err_s;
  logic                  sramRdEn_s, sramWrEn_s;
  logic [IDX_W-1:0]      sramIdx_s;
  logic [31:0]           sramRdata_s;

  // Next-state and latency-counter logic.
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && reqReady_r) begin
          accept_s = 1'b1;
          if (LATENCY > 1) begin
            nextState_s = ST_WAIT;
            nextCnt_s   = CNT_W'(LATENCY - 1);
          end else begin
            nextState_s = ST_RESP;
          end
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      // The access is launched on the edge where the count reaches zero.
      ST_WAIT: begin
        nextCnt_s = cnt_r - CNT_W'(1);
        if (cnt_r <= CNT_W'(1)) begin
          nextState_s = ST_RESP;
        end else begin
          nextState_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          nextState_s = ST_IDLE;
        end else begin
          nextState_s = ST_RESP;
        end
      end
      default: begin
        nextState_s = ST_IDLE;
        nextCnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // With LATENCY=1 the access happens on the accept edge, before the latch.
  always_comb begin
    if (state_r == ST_IDLE) begin
      curAddr_s = req_addr;
      curWen_s  = req_wen;
      curInst_s = req_load_inst;
      curMask_s = req_store_mask;
      curData_s = req_store_data;
    end else begin
      curAddr_s = addr_r;
      curWen_s  = wen_r;
      curInst_s = inst_r;
      curMask_s = mask_r;
      curData_s = data_r;
    end
  end

  // Range, alignment and load-type checks on the request being serviced.
  always_comb begin
    offset_s  = curAddr_s - BASE_ADDR;
    inRange_s = (curAddr_s >= BASE_ADDR) && ((offset_s >> 2) < DEPTH_LIMIT);
    case (curInst_s)
      LH, LHU: misaligned_s = curAddr_s[0];
      LW:      misaligned_s = (curAddr_s[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
    case (curInst_s)
      LB, LH, LW, LBU, LHU: illegal_s = 1'b0;
      default:              illegal_s = 1'b1;
    endcase
    err_s       = !inRange_s || (!curWen_s && (misaligned_s || illegal_s));
    enterResp_s = !rst && (nextState_s == ST_RESP) && (state_r != ST_RESP);
    sramRdEn_s  = enterResp_s && !curWen_s;
    sramWrEn_s  = enterResp_s && curWen_s && inRange_s && (curMask_s != 4'b0000);
    sramIdx_s   = offset_s[IDX_W+1:2];
  end

  // State, request latch and registered response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      reqReady_r  <= 1'b0;
      respValid_r <= 1'b0;
      respErr_r   <= 1'b0;
      loadOk_r    <= 1'b0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wen_r       <= 1'b0;
      inst_r      <= 3'b000;
      mask_r      <= 4'b0000;
      data_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= nextState_s;
      cnt_r       <= nextCnt_s;
      reqReady_r  <= (nextState_s == ST_IDLE);
      respValid_r <= (nextState_s == ST_RESP);
      if (accept_s) begin
        addr_r <= req_addr;
        wen_r  <= req_wen;
        inst_r <= req_load_inst;
        mask_r <= req_store_mask;
        data_r <= req_store_data;
      end
      if (enterResp_s) begin
        respErr_r <= err_s;
        loadOk_r  <= !curWen_s && !err_s;
      end else if (nextState_s != ST_RESP) begin
        respErr_r <= 1'b0;
        loadOk_r  <= 1'b0;
      end
    end
  end

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk   (clk),
    .rdEn  (sramRdEn_s),
    .rdIdx (sramIdx_s),
    .rdData(sramRdata_s),
    .wrEn  (sramWrEn_s),
    .wrIdx (sramIdx_s),
    .wrMask(curMask_s),
    .wrData(curData_s)
  );

  assign req_ready  = reqReady_r;
  assign resp_valid = respValid_r;
  assign resp_err   = respErr_r;
  assign resp_rdata = loadOk_r ? load_extend(sramRdata_s, addr_r[1:0], inst_r)
                               : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=1 instance driven from a
// vector table and a LATENCY=4 instance for stall and reset corner cases.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, reqValid, reqWen, respReady;
  logic [1:0][31:0] reqAddr, reqData;
  logic [1:0][2:0]  reqInst;
  logic [1:0][3:0]  reqMask;
  wire  [1:0]       reqReady, respValid, respErr;
  wire  [1:0][31:0] respRdata;

  int nChecks = 0;
  int nFail   = 0;

  dmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_addr(reqAddr[0]), .req_wen(reqWen[0]), .req_load_inst(reqInst[0]),
    .req_store_mask(reqMask[0]), .req_store_data(reqData[0]),
    .resp_valid(respValid[0]), .resp_ready(respReady[0]),
    .resp_rdata(respRdata[0]), .resp_err(respErr[0])
  );

  dmem_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_addr(reqAddr[1]), .req_wen(reqWen[1]), .req_load_inst(reqInst[1]),
    .req_store_mask(reqMask[1]), .req_store_data(reqData[1]),
    .resp_valid(respValid[1]), .resp_ready(respReady[1]),
    .resp_rdata(respRdata[1]), .resp_err(respErr[1])
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [2:0]  inst;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic wen, logic [31:0] addr, logic [2:0] inst, logic [3:0] mask,
                              logic [31:0] data, logic [31:0] expRdata, logic expErr);
    vec_t v;
    v.wen = wen; v.addr = addr; v.inst = inst; v.mask = mask;
    v.data = data; v.expRdata = expRdata; v.expErr = expErr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // One transaction, entered and left at a negedge. hold = cycles resp_ready stays low.
  task automatic doTxn(input int d, input logic wen, input logic [31:0] addr, input logic [2:0] inst,
                       input logic [3:0] mask, input logic [31:0] data, input logic [31:0] expRdata,
                       input logic expErr, input int hold, input string tag);
    int lat;
    int waitc;
    respReady[d] = (hold == 0);
    waitc = 0;
    while (reqReady[d] !== 1'b1 && waitc < 20) begin
      @(posedge clk); @(negedge clk);
      waitc++;
    end
    check({tag, " req_ready before accept"}, {31'd0, reqReady[d]}, 32'd1);
    reqValid[d] = 1'b1; reqWen[d] = wen; reqAddr[d] = addr;
    reqInst[d] = inst; reqMask[d] = mask; reqData[d] = data;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    reqValid[d] = 1'b0;
    while (respValid[d] !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(latOf(d)));
    check({tag, " rdata"}, respRdata[d], expRdata);
    check({tag, " err"}, {31'd0, respErr[d]}, {31'd0, expErr});
    check({tag, " req_ready in RESP"}, {31'd0, reqReady[d]}, 32'd0);
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("%s hold%0d valid", tag, h), {31'd0, respValid[d]}, 32'd1);
      check($sformatf("%s hold%0d rdata", tag, h), respRdata[d], expRdata);
      check($sformatf("%s hold%0d req_ready", tag, h), {31'd0, reqReady[d]}, 32'd0);
    end
    respReady[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    check({tag, " valid after handshake"}, {31'd0, respValid[d]}, 32'd0);
    check({tag, " req_ready after handshake"}, {31'd0, reqReady[d]}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11; reqValid = 2'b00; reqWen = 2'b00; respReady = 2'b11;
    reqAddr = '0; reqData = '0; reqInst = '0; reqMask = '0;

    vecs[0]  = mk(1'b1, 32'h8000_0000, LW,     4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    vecs[1]  = mk(1'b0, 32'h8000_0000, LW,     4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0);
    vecs[2]  = mk(1'b0, 32'h8000_0003, LB,     4'b0000, 32'h0,         32'hFFFF_FFDE, 1'b0);
    vecs[3]  = mk(1'b0, 32'h8000_0003, LBU,    4'b0000, 32'h0,         32'h0000_00DE, 1'b0);
    vecs[4]  = mk(1'b0, 32'h8000_0002, LH,     4'b0000, 32'h0,         32'hFFFF_DEAD, 1'b0);
    vecs[5]  = mk(1'b0, 32'h8000_0000, LHU,    4'b0000, 32'h0,         32'h0000_BEEF, 1'b0);
    vecs[6]  = mk(1'b1, 32'h8000_0000, LW,     4'b0010, 32'h0000_5500, 32'h0000_0000, 1'b0);
    vecs[7]  = mk(1'b0, 32'h8000_0000, LW,     4'b0000, 32'h0,         32'hDEAD_55EF, 1'b0);
    vecs[8]  = mk(1'b1, 32'h8000_0000, LW,     4'b0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    vecs[9]  = mk(1'b0, 32'h8000_0000, LW,     4'b0000, 32'h0,         32'hDEAD_55EF, 1'b0);
    vecs[10] = mk(1'b0, 32'h8000_0001, LB,     4'b0000, 32'h0,         32'h0000_0055, 1'b0);
    vecs[11] = mk(1'b0, 32'h8000_0002, LW,     4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    vecs[12] = mk(1'b0, 32'h8000_0001, LH,     4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    vecs[13] = mk(1'b0, 32'h7FFF_FFFC, LW,     4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    vecs[14] = mk(1'b0, 32'h8000_1000, LW,     4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    vecs[15] = mk(1'b0, 32'h8000_0000, 3'b011, 4'b0000, 32'h0,         32'h0000_0000, 1'b1);
    vecs[16] = mk(1'b1, 32'h8000_1000, LW,     4'b1111, 32'h1234_5678, 32'h0000_0000, 1'b1);
    vecs[17] = mk(1'b0, 32'h8000_0000, LW,     4'b0000, 32'h0,         32'hDEAD_55EF, 1'b0);
    vecs[18] = mk(1'b1, 32'h8000_0FFC, LW,     4'b1111, 32'hA5C3_0F96, 32'h0000_0000, 1'b0);
    vecs[19] = mk(1'b0, 32'h8000_0FFD, LB,     4'b0000, 32'h0,         32'h0000_000F, 1'b0);
    vecs[20] = mk(1'b0, 32'h8000_0FFE, LH,     4'b0000, 32'h0,         32'hFFFF_A5C3, 1'b0);
    vecs[21] = mk(1'b0, 32'h8000_0FFC, LBU,    4'b0000, 32'h0,         32'h0000_0096, 1'b0);

    // Reset state.
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d resp_valid", d), {31'd0, respValid[d]}, 32'd0);
      check($sformatf("reset%0d resp_rdata", d), respRdata[d], 32'd0);
      check($sformatf("reset%0d resp_err", d), {31'd0, respErr[d]}, 32'd0);
      check($sformatf("reset%0d req_ready", d), {31'd0, reqReady[d]}, 32'd0);
    end
    rst = 2'b00;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("post-reset%0d req_ready", d), {31'd0, reqReady[d]}, 32'd1);
    end

    // LATENCY=1 vector table.
    for (int i = 0; i < 22; i++) begin
      doTxn(0, vecs[i].wen, vecs[i].addr, vecs[i].inst, vecs[i].mask, vecs[i].data,
            vecs[i].expRdata, vecs[i].expErr, 0, $sformatf("vec%0d", i));
    end

    // LATENCY=4: seed a word, then read it with resp_ready low for 3 cycles.
    doTxn(1, 1'b1, 32'h8000_0010, LW, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, 0, "l4 store");
    doTxn(1, 1'b0, 32'h8000_0010, LW, 4'b0000, 32'h0, 32'h1122_3344, 1'b0, 3, "l4 stall load");

    // LATENCY=4: reset during cycle T+2 of a store aborts it.
    reqValid[1] = 1'b1; reqWen[1] = 1'b1; reqAddr[1] = 32'h8000_0010;
    reqInst[1] = LW; reqMask[1] = 4'b1111; reqData[1] = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    reqValid[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst[1] = 1'b0;
    check("abort req_ready in reset", {31'd0, reqReady[1]}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("abort c%0d resp_valid", c), {31'd0, respValid[1]}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    doTxn(1, 1'b0, 32'h8000_0010, LW, 4'b0000, 32'h0, 32'h1122_3344, 1'b0, 0, "l4 after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the NPC core: the slave end of the load/store request stream that the memory stage issues (load type, byte store mask, store data). It accepts one request at a time over a valid/ready handshake, holds a word-organised SRAM model, and returns a sign- or zero-extended load result or a store acknowledge after a programmable latency. It sits between the memory stage and the data address space, replacing the combinational data-memory path so the core can be moved to a multi-cycle memory stage.

## Interface
- DATA_WIDTH, 32, data word width; fixed at 32 for this revision
- ADDR_WIDTH, 32, byte-address width
- DEPTH_WORDS, 1024, SRAM depth in 32-bit words (power of two)
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- LATENCY, 1, cycles from acceptance to resp_valid (≥1)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_addr  in  ADDR_WIDTH  byte address
- req_wen  in  1  1 = store, 0 = load
- req_load_inst  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others illegal
- req_store_mask  in  4  byte enables for stores, bit i = byte lane i
- req_store_data  in  DATA_WIDTH  lane-aligned store data
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range, or illegal load type

## Operation
- FSM states IDLE, WAIT, RESP; reset → IDLE.
- IDLE: req_ready=1. On req_valid: latch request; go WAIT with cnt=LATENCY-1 if LATENCY>1, else RESP.
- WAIT: req_ready=0; cnt decrements each cycle; at cnt=0 transition to RESP.
- On the edge entering RESP: perform access, register resp_rdata/resp_err.
- RESP: resp_valid=1, outputs stable until resp_ready; on resp_ready go IDLE (no same-cycle acceptance of next request).
- Range: index=(addr-BASE_ADDR)>>2; out of range if addr<BASE_ADDR or index≥DEPTH_WORDS → err, no write.
- Alignment: lh/lhu need addr[0]=0; lw needs addr[1:0]=0; misaligned → err. Stores are not alignment-checked; mask selects lanes.
- Load: lane select by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend.
- Store: write only lanes with mask bit set; mask 4'b0000 → no write, resp_err=0, acknowledge normally.
- Memory contents not cleared by rst.

## Timing
- Reset values: req_ready=0 during rst cycle, 1 in first cycle after; resp_valid=0, resp_rdata=0, resp_err=0.
- Accept at cycle T (req_valid&&req_ready) → resp_valid first high in cycle T+LATENCY.
- Store commits at the edge ending cycle T+LATENCY-1; load issued later sees it.
- Back-to-back throughput: one transaction per LATENCY+1 cycles with resp_ready held high.
- resp_ready low: RESP holds indefinitely, req_ready stays 0.
- rst mid-WAIT or mid-RESP: abort to IDLE, drop response; a store not yet committed is not written.

## Structure
- Package dmem_pkg: load-type localparams (LB, LH, LW, LBU, LHU), state encoding, function load_extend(word, offset, load_inst).
- Sub-module dmem_sram: DEPTH_WORDS×32 array, one registered read port and one byte-masked write port, same clk.
- Top holds FSM, latency counter, request latch, range/alignment checks.

## Test plan
- LATENCY=1: store addr 0x8000_0000 mask 1111 data 0xDEAD_BEEF, then lw same → resp_rdata 0xDEAD_BEEF, err 0, resp_valid one cycle after each accept.
- Byte/half extension: after above, lb 0x8000_0003 → 0xFFFF_FFDE; lbu → 0x0000_00DE; lh 0x8000_0002 → 0xFFFF_DEAD; lhu 0x8000_0000 → 0x0000_BEEF.
- Partial store: mask 0010 data 0x0000_5500 to 0x8000_0000 → lw returns 0xDEAD_55EF; mask 0000 → err 0, contents unchanged.
- Errors: lw 0x8000_0002, lh 0x8000_0001, lw 0x7FFF_FFFC, lw BASE+4*DEPTH_WORDS, load_inst 011 → each resp_err 1, rdata 0.
- LATENCY=4 with resp_ready low 3 cycles: resp_valid at T+4, held with stable data until resp_ready, req_ready 0 throughout, then 1.
- Reset at T+2 of a LATENCY=4 store → resp_valid never asserts; subsequent lw returns pre-store data.
